rr_arb_mux: RTL and testbench
=============================

// Module: rr_arb_mux
// PURPOSE
//  Parametrised N:1 datapath selector with round-robin arbitration and a
//  valid/ready handshake on every input and on the output. Next generation of
//  the 64-bit 4:1 mux: the select is generated internally, and the output is
//  registered. Feeds shared resources such as the regfile write port or a
//  memory request bus from multiple requesters.
// PARAMETERS
//  WIDTH  64           data width per channel
//  N      4            number of input channels (>=1)
//  SELW   $clog2(N)>1  width of out_src; forced to 1 when N==1
// PORTS
//  clk        in   1        rising-edge clock, single clock domain
//  reset_n    in   1        synchronous, active-low reset
//  in_data    in   N*WIDTH  channel i occupies [i*WIDTH +: WIDTH]
//  in_valid   in   N        channel i presents a beat
//  in_ready   out  N        channel i beat accepted this cycle when valid&ready
//  out_data   out  WIDTH    registered selected beat
//  out_valid  out  1        out_data holds a beat
//  out_ready  in   1        downstream accepts the beat when valid&ready
//  out_src    out  SELW     index of the channel that supplied out_data
// BEHAVIOUR
//  - Reset (reset_n==0 at posedge): out_valid=0, out_data=0, out_src=0,
//    rr pointer=0, lock=0. Any held beat is discarded. in_ready is all-zero
//    while reset_n==0.
//  - Output register loads when it is empty or being drained:
//    load_en = ~out_valid | out_ready.
//  - Grant (combinational): first channel with in_valid=1, searched from the
//    pointer upward, wrapping N-1 -> 0. At most one grant bit is set.
//  - in_ready[i] = grant[i] & load_en. in_ready never depends on in_valid of
//    channel i alone; there is no combinational path from out_ready to out_*.
//  - Accept (any in_valid&in_ready): next cycle out_valid=1,
//    out_data=granted beat, out_src=granted index, pointer=(index+1) mod N.
//  - No accept and out_ready=1: out_valid goes 0; out_data/out_src hold.
//  - out_valid=1 and out_ready=0: out_data/out_src/out_valid stable; all
//    in_ready=0.
//  - Latency 1 cycle input->output. Full throughput of 1 beat/cycle with
//    out_ready held high.
//  - Fairness: with all channels valid continuously, grants cycle
//    0,1,..,N-1,0 with no channel skipped or repeated.
//  - No valid inputs: pointer holds.
//  - N==1: grant = in_valid[0]; pointer stays 0; out_src=0.
// CONFIGURATION
//  ARB_LOCK_EN defined: adds ports in_last [N] (in) and out_last [1] (out,
//    reset 0, registered with out_data). After a beat with in_last=0 is
//    accepted from channel k, the grant stays locked on k until a beat from k
//    with in_last=1 is accepted; other channels get in_ready=0 meanwhile even
//    if k drops valid. The pointer advances only on the last beat. Reset
//    clears the lock.
//  ARB_LOCK_EN undefined: no in_last/out_last ports; arbitration runs every
//    beat as above.
// TESTING
//  1 Reset: hold reset_n=0 3 cycles with all valid -> out_valid=0,
//    out_data=0, in_ready=0; release -> first beat from ch0 after 1 cycle.
//  2 All 4 valid, out_ready=1, ch i data=0x1111*i(i+1) -> out_src
//    0,1,2,3,0 on consecutive cycles, 1 beat/cycle, data matches.
//  3 Only ch2 valid, out_ready=0 for 5 cycles -> out_data/out_src=2 stable,
//    in_ready=0; raise out_ready -> drain then accept next ch2 beat.
//  4 Pointer at 3, ch1 and ch2 valid -> ch1 is not granted before ch2?
//    check: search 3,0,1 -> ch1 granted, pointer becomes 2, then ch2.
//  5 reset_n=0 while out_valid=1, out_ready=0 -> next cycle out_valid=0,
//    beat dropped, pointer=0.
//  6 ARB_LOCK_EN: ch0 sends 3-beat packet (last on beat 3) with ch1 valid
//    throughout -> out_src 0,0,0 then 1; out_last=1 only on third beat.

Source files
------------

// File: rtl/rr_arb_mux.sv
// N:1 round-robin arbitrated mux with valid/ready on every input and a registered output.
// Optional packet locking (in_last/out_last) enabled by defining ARB_LOCK_EN.
module rr_arb_mux #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned N     = 4,
    parameter int unsigned SELW  = (N > 1) ? $clog2(N) : 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [N*WIDTH-1:0]   in_data,
    input  logic [N-1:0]         in_valid,
    output logic [N-1:0]         in_ready,
`ifdef ARB_LOCK_EN
    input  logic [N-1:0]         in_last,
    output logic                 out_last,
`endif
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [SELW-1:0]      out_src
);

    // One extra bit so ptr+offset can exceed N-1 before wrapping.
    localparam int unsigned CNTW = SELW + 1;

    logic                out_valid_q, out_valid_d;
    logic [WIDTH-1:0]    out_data_q,  out_data_d;
    logic [SELW-1:0]     out_src_q,   out_src_d;
    logic [SELW-1:0]     ptr_q,       ptr_d;
`ifdef ARB_LOCK_EN
    logic                lock_q,      lock_d;
    logic                out_last_q,  out_last_d;
`endif

    logic                load_en_c;
    logic [N-1:0]        grant_c;
    logic [SELW-1:0]     gnt_idx_c;
    logic                found_c;
    logic [CNTW-1:0]     cand_c;
    logic [CNTW-1:0]     ptr_inc_c;
    logic [WIDTH-1:0]    sel_data_c;
    logic                accept_c;

    assign load_en_c = ~out_valid_q | out_ready;

    // Grant: first valid channel searched upward from the pointer, wrapping.
    always_comb begin
        grant_c   = '0;
        gnt_idx_c = '0;
        found_c   = 1'b0;
        cand_c    = '0;
`ifdef ARB_LOCK_EN
        // While locked, out_src_q still names the channel that owns the packet.
        if (lock_q) begin
            if (in_valid[out_src_q]) begin
                grant_c[out_src_q] = 1'b1;
                gnt_idx_c          = out_src_q;
            end
        end else
`endif
        begin
            for (int unsigned off = 0; off < N; off++) begin
                cand_c = CNTW'(ptr_q) + CNTW'(off);
                if (cand_c >= CNTW'(N)) begin
                    cand_c = cand_c - CNTW'(N);
                end
                if (!found_c && in_valid[cand_c[SELW-1:0]]) begin
                    found_c                     = 1'b1;
                    grant_c[cand_c[SELW-1:0]]   = 1'b1;
                    gnt_idx_c                   = cand_c[SELW-1:0];
                end
            end
        end
    end

    assign in_ready = reset_n ? (grant_c & {N{load_en_c}}) : '0;
    assign accept_c = |(in_valid & in_ready);

    always_comb begin
        sel_data_c = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (grant_c[i]) begin
                sel_data_c = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        ptr_inc_c = CNTW'(gnt_idx_c) + CNTW'(1);
        if (ptr_inc_c >= CNTW'(N)) begin
            ptr_inc_c = '0;
        end
    end

    // Output register and arbitration state update.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        ptr_d       = ptr_q;
`ifdef ARB_LOCK_EN
        lock_d      = lock_q;
        out_last_d  = out_last_q;
`endif
        if (accept_c) begin
            out_valid_d = 1'b1;
            out_data_d  = sel_data_c;
            out_src_d   = gnt_idx_c;
`ifdef ARB_LOCK_EN
            out_last_d  = in_last[gnt_idx_c];
            lock_d      = ~in_last[gnt_idx_c];
            if (in_last[gnt_idx_c]) begin
                ptr_d = ptr_inc_c[SELW-1:0];
            end
`else
            ptr_d       = ptr_inc_c[SELW-1:0];
`endif
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= '0;
            ptr_q       <= '0;
`ifdef ARB_LOCK_EN
            lock_q      <= 1'b0;
            out_last_q  <= 1'b0;
`endif
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
            ptr_q       <= ptr_d;
`ifdef ARB_LOCK_EN
            lock_q      <= lock_d;
            out_last_q  <= out_last_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;
`ifdef ARB_LOCK_EN
    assign out_last  = out_last_q;
`endif

endmodule

// File: tb/tb_rr_arb_mux.sv
// Bench for rr_arb_mux: per-cycle comparison against a behavioural arbiter model
// plus directed scenarios with literal expectations.
module tb_rr_arb_mux;

    localparam int unsigned W = 64;
    localparam int unsigned N = 4;
    localparam int unsigned SELW = 2;
`ifdef ARB_LOCK_EN
    localparam bit LOCK = 1'b1;
`else
    localparam bit LOCK = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               reset_n;
    logic [W-1:0]       d [N];
    logic [N*W-1:0]     in_data;
    logic [N-1:0]       in_valid;
    logic [N-1:0]       in_ready;
    logic [N-1:0]       in_last;
    logic [W-1:0]       out_data;
    logic               out_valid;
    logic               out_ready;
    logic [SELW-1:0]    out_src;
`ifdef ARB_LOCK_EN
    logic               out_last;
`endif

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    bit          m_valid = 0;
    logic [W-1:0] m_data = '0;
    int          m_src = 0;
    int          m_ptr = 0;
    bit          m_lock = 0;
    int          m_lockch = 0;
    bit          m_last = 0;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < int'(N); i++) in_data[i*W +: W] = d[i];
    end

    rr_arb_mux #(.WIDTH(W), .N(N)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
`ifdef ARB_LOCK_EN
        .in_last  (in_last),
        .out_last (out_last),
`endif
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_src  (out_src)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Which channel should be accepted this cycle, or -1.
    function automatic int model_pick();
        if (!reset_n) return -1;
        if (m_valid && !out_ready) return -1;
        if (m_lock) return in_valid[m_lockch] ? m_lockch : -1;
        for (int k = 0; k < int'(N); k++) begin
            if (in_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    always @(posedge clk) begin
        int g;
        g = model_pick();
        if (!reset_n) begin
            m_valid = 0; m_data = '0; m_src = 0; m_ptr = 0; m_lock = 0; m_last = 0;
        end else if (g >= 0) begin
            m_valid = 1;
            m_data  = d[g];
            m_src   = g;
            m_last  = in_last[g];
            if (LOCK && !in_last[g]) begin
                m_lock   = 1;
                m_lockch = g;
            end else begin
                m_lock = 0;
                m_ptr  = (g + 1) % N;
            end
        end else if (out_ready) begin
            m_valid = 0;
        end
    end

    always @(negedge clk) begin
        int g;
        logic [N-1:0] exp_rdy;
        g = model_pick();
        exp_rdy = (g >= 0) ? (N'(1) << g) : '0;
        chk("model in_ready", 64'(in_ready), 64'(exp_rdy));
        chk("model out_valid", 64'(out_valid), 64'(m_valid));
        chk("model out_data", out_data, m_data);
        chk("model out_src", 64'(out_src), 64'(m_src));
`ifdef ARB_LOCK_EN
        chk("model out_last", 64'(out_last), 64'(m_last));
`endif
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n   = 1'b0;
        in_valid  = '1;
        in_last   = '1;
        out_ready = 1'b1;
        for (int i = 0; i < int'(N); i++) d[i] = W'(64'h1111 * i * (i + 1));

        // 1: reset held with all valid
        repeat (3) tick();
        chk("rst out_valid", 64'(out_valid), 64'd0);
        chk("rst out_data", out_data, 64'd0);
        chk("rst in_ready", 64'(in_ready), 64'd0);
        reset_n = 1'b1;
        #1;
        chk("post-rst in_ready", 64'(in_ready), 64'b0001);
        tick();
        chk("first beat valid", 64'(out_valid), 64'd1);
        chk("first beat src", 64'(out_src), 64'd0);

        // 2: round robin with all valid
        tick(); chk("rr src1", 64'(out_src), 64'd1); chk("rr data1", out_data, 64'h2222);
        tick(); chk("rr src2", 64'(out_src), 64'd2); chk("rr data2", out_data, 64'h6666);
        tick(); chk("rr src3", 64'(out_src), 64'd3); chk("rr data3", out_data, 64'hCCCC);
        tick(); chk("rr src0", 64'(out_src), 64'd0); chk("rr valid", 64'(out_valid), 64'd1);

        // 3: only ch2, stalled output
        in_valid = 4'b0100;
        tick();
        chk("ch2 src", 64'(out_src), 64'd2);
        out_ready = 1'b0;
        d[2] = 64'hABCD;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall src", 64'(out_src), 64'd2);
            chk("stall data", out_data, 64'h6666);
            chk("stall in_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        #1;
        chk("unstall in_ready", 64'(in_ready), 64'b0100);
        tick();
        chk("drain+accept data", out_data, 64'hABCD);
        chk("drain+accept valid", 64'(out_valid), 64'd1);

        // 4: pointer at 3, ch1 and ch2 valid
        in_valid = 4'b0110;
        tick(); chk("wrap src1", 64'(out_src), 64'd1);
        tick(); chk("wrap src2", 64'(out_src), 64'd2);

        // 5: reset while holding a stalled beat
        in_valid  = '1;
        out_ready = 1'b0;
        tick();
        chk("hold before rst", 64'(out_valid), 64'd1);
        reset_n = 1'b0;
        tick();
        chk("rst drop valid", 64'(out_valid), 64'd0);
        chk("rst drop data", out_data, 64'd0);
        reset_n   = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("rst ptr0 in_ready", 64'(in_ready), 64'b0001);
        tick();
        chk("rst ptr0 src", 64'(out_src), 64'd0);

        // idle: no valid inputs, pointer must hold at 1
        in_valid = '0;
        repeat (2) tick();
        chk("idle valid", 64'(out_valid), 64'd0);
        in_valid = 4'b1011;
        #1;
        chk("idle ptr hold", 64'(in_ready), 64'b0010);
        tick();

`ifdef ARB_LOCK_EN
        // 6: 3-beat packet from ch0 with ch1 contending
        reset_n = 1'b0;
        tick();
        reset_n  = 1'b1;
        in_valid = 4'b0011;
        in_last  = 4'b1110;
        tick();
        chk("pkt b1 src", 64'(out_src), 64'd0);
        chk("pkt b1 last", 64'(out_last), 64'd0);
        in_valid = 4'b0010;
        #1;
        chk("lock in_ready", 64'(in_ready), 64'd0);
        tick();
        chk("lock gap valid", 64'(out_valid), 64'd0);
        in_valid = 4'b0011;
        tick();
        chk("pkt b2 src", 64'(out_src), 64'd0);
        chk("pkt b2 last", 64'(out_last), 64'd0);
        in_last = 4'b1111;
        tick();
        chk("pkt b3 src", 64'(out_src), 64'd0);
        chk("pkt b3 last", 64'(out_last), 64'd1);
        tick();
        chk("after pkt src", 64'(out_src), 64'd1);
`endif

        in_valid = '0;
        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
